// File: rtl/mem_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master_if
// Description : Request/response handshake and memory-mapped bus signals
//               between the CPU datapath, mem_bus_master and the board-level
//               memory/IO decode. The master modport is the sequencer's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    // Datapath request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Datapath response channel (no backpressure)
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    // Memory-mapped bus
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, read_data,
        output req_ready, rsp_valid, rsp_rdata, mem_cmd, mem_addr, write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, read_data,
        input  req_ready, rsp_valid, rsp_rdata, mem_cmd, mem_addr, write_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Turns single load/store requests into MREAD/MWRITE cycles on
//               the memory-mapped bus, holds MREAD for RD_WAIT+1 cycles,
//               captures read data and returns a one-cycle rsp_valid pulse.
//               Optional feature macro: MEM_REQBUF_EN adds a one-entry
//               request buffer so transactions can run back-to-back.
//               RD_WAIT legal range is 1..3 (2-bit read counter).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_master_if.master  bus
);

    localparam logic [1:0] c_MNONE  = 2'b00;
    localparam logic [1:0] c_MREAD  = 2'b01;
    localparam logic [1:0] c_MWRITE = 2'b10;
    localparam logic [1:0] c_RD_CNT = 2'(RD_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                req_ready;
    logic                accept;
    logic                launch;
    logic                l_write;
    logic [ADDR_W-1:0]   l_addr;
    logic [DATA_W-1:0]   l_wdata;

`ifdef MEM_REQBUF_EN
    logic                buf_valid_q, buf_valid_d;
    logic                buf_write_q, buf_write_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_wdata_q, buf_wdata_d;
    logic                last_busy;

    // Buffer frees up only when the FSM launches its contents
    assign req_ready = ~buf_valid_q & ~reset;
    assign last_busy = (state_q == S_WR) || ((state_q == S_RD) && (cnt_q == 2'd0));
`else
    assign req_ready = (state_q == S_IDLE) & ~reset;
`endif

    assign accept = bus.req_valid & req_ready;

    // Next-state, launch selection and completion logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        write_data_d = write_data_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        mem_cmd_d    = c_MNONE;
        launch       = 1'b0;
        l_write      = bus.req_write;
        l_addr       = bus.req_addr;
        l_wdata      = bus.req_wdata;
`ifdef MEM_REQBUF_EN
        buf_valid_d  = buf_valid_q;
        buf_write_d  = buf_write_q;
        buf_addr_d   = buf_addr_q;
        buf_wdata_d  = buf_wdata_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    launch = 1'b1;
                end
            end
            S_WR: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
            end
            S_RD: begin
                if (cnt_q == 2'd0) begin
                    // Sample on the edge that ends the last MREAD cycle;
                    // whatever the bus shows is taken as-is.
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.read_data;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MEM_REQBUF_EN
        if (last_busy) begin
            // Chain the next transaction without an MNONE gap: buffered
            // request first, otherwise one arriving in this very cycle.
            if (buf_valid_q) begin
                launch      = 1'b1;
                l_write     = buf_write_q;
                l_addr      = buf_addr_q;
                l_wdata     = buf_wdata_q;
                buf_valid_d = 1'b0;
            end else if (accept) begin
                launch = 1'b1;
            end
        end else if ((state_q != S_IDLE) && accept) begin
            buf_valid_d = 1'b1;
            buf_write_d = bus.req_write;
            buf_addr_d  = bus.req_addr;
            buf_wdata_d = bus.req_wdata;
        end
`endif

        if (launch) begin
            state_d      = l_write ? S_WR : S_RD;
            cnt_d        = c_RD_CNT;
            mem_addr_d   = l_addr;
            write_data_d = l_wdata;
        end

        // Bus command is registered alongside the state it encodes
        unique case (state_d)
            S_WR:    mem_cmd_d = c_MWRITE;
            S_RD:    mem_cmd_d = c_MREAD;
            default: mem_cmd_d = c_MNONE;
        endcase
    end

    // FSM, bus and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            mem_cmd_q    <= c_MNONE;
            mem_addr_q   <= '0;
            write_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            write_data_q <= write_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

`ifdef MEM_REQBUF_EN
    // One-entry request buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_write_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_write_q <= buf_write_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end
`endif

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.mem_cmd    = mem_cmd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.write_data = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Self-checking bench for mem_bus_master. Two instances
//               (RD_WAIT=1 and RD_WAIT=3) drive a small bus model with a
//               synchronous-read RAM, LED and switch registers. Expected
//               responses go into per-instance queues at request acceptance
//               and are compared (data and cycle) when rsp_valid pulses.
//               MEM_REQBUF_EN selects the back-to-back sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

    localparam int AW = 9;
    localparam int DW = 16;

    typedef struct {
        logic [15:0] rd;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t m1;
    exp_t m3;
    logic [15:0] last1 = 16'h0000;
    logic [15:0] ram [256];
    logic [15:0] led1;

    mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bus_lookup(input logic [8:0] a);
        if (a == 9'h140) return 16'h003C;
        else if (a[8])   return ram[a[7:0]];
        else             return 16'h0000;
    endfunction

    // Board model: switch/RAM reads registered (synchronous RAM), LED and RAM writes
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'hC000 | 16'(i);
            ram[8'hFF] <= 16'hBEEF;
            led1       <= 16'h0000;
        end else if (bus1.mem_cmd == 2'b10) begin
            if (bus1.mem_addr == 9'h100)
                led1 <= bus1.write_data;
            else if (bus1.mem_addr != 9'h140 && bus1.mem_addr[8])
                ram[bus1.mem_addr[7:0]] <= bus1.write_data;
        end
        bus1.read_data <= (bus1.mem_cmd == 2'b01) ? bus_lookup(bus1.mem_addr) : 16'h0000;
        bus3.read_data <= (bus3.mem_cmd == 2'b01) ? bus_lookup(bus3.mem_addr) : 16'h0000;
    end

    // Response scoreboards
    always @(negedge clk) begin
        if (bus1.rsp_valid) begin
            if (q1.size() == 0) begin
                check_eq("rsp1_unexpected", 32'(bus1.rsp_valid), 32'd0);
            end else begin
                m1 = q1.pop_front();
                check_eq("rsp1_rdata", 32'(bus1.rsp_rdata), 32'(m1.rd));
                check_eq("rsp1_cycle", cyc, m1.due);
            end
        end
        if (bus3.rsp_valid) begin
            if (q3.size() == 0) begin
                check_eq("rsp3_unexpected", 32'(bus3.rsp_valid), 32'd0);
            end else begin
                m3 = q3.pop_front();
                check_eq("rsp3_rdata", 32'(bus3.rsp_rdata), 32'(m3.rd));
                check_eq("rsp3_cycle", cyc, m3.due);
            end
        end
    end

    // Drive one request into instance 1 (called and returns at a negedge,
    // returning in the first cycle of the transaction)
    task automatic send1(input logic wr, input logic [8:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, output int n);
        int guard = 0;
        bus1.req_valid = 1'b1;
        bus1.req_write = wr;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        while (!bus1.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("acc1_ready", 32'(bus1.req_ready), 32'd1);
        n = cyc;
        if (wr) begin
            q1.push_back(exp_t'{rd: last1, due: n + 2});
        end else begin
            q1.push_back(exp_t'{rd: exp_rd, due: n + 3});
            last1 = exp_rd;
        end
        @(negedge clk);
        bus1.req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int n2;
        int guard;
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd",   32'(bus1.mem_cmd), 32'd0);
        check_eq("rst_ready", 32'(bus1.req_ready), 32'd0);
        check_eq("rst_rsp",   32'(bus1.rsp_valid), 32'd0);
        check_eq("rst_addr",  32'(bus1.mem_addr), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        #1;
        check_eq("rel_ready", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);

        // Store to LEDs: one MWRITE cycle, rsp_rdata untouched
        send1(1'b1, 9'h100, 16'h00A5, 16'h0000, n);
        check_eq("st_cmd",   32'(bus1.mem_cmd), 32'd2);
        check_eq("st_addr",  32'(bus1.mem_addr), 32'h100);
        check_eq("st_wdata", 32'(bus1.write_data), 32'h00A5);
`ifndef MEM_REQBUF_EN
        check_eq("st_busy_ready", 32'(bus1.req_ready), 32'd0);
`endif
        @(negedge clk);
        check_eq("st_cmd_end",   32'(bus1.mem_cmd), 32'd0);
        check_eq("st_addr_hold", 32'(bus1.mem_addr), 32'h100);
        check_eq("st_ready_end", 32'(bus1.req_ready), 32'd1);
        check_eq("st_led",       32'(led1), 32'h00A5);

        // Load switches, RD_WAIT=1: two MREAD cycles
        send1(1'b0, 9'h140, 16'h5555, 16'h003C, n);
        check_eq("ld_cmd1",  32'(bus1.mem_cmd), 32'd1);
        check_eq("ld_addr",  32'(bus1.mem_addr), 32'h140);
        check_eq("ld_wdata", 32'(bus1.write_data), 32'h5555);
        @(negedge clk);
        check_eq("ld_cmd2", 32'(bus1.mem_cmd), 32'd1);
        @(negedge clk);
        check_eq("ld_cmd_end", 32'(bus1.mem_cmd), 32'd0);

`ifdef MEM_REQBUF_EN
        // Store, load and store on consecutive cycles: no MNONE gaps
        bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 9'h180; bus1.req_wdata = 16'h1111;
        check_eq("bf_ready0", 32'(bus1.req_ready), 32'd1);
        n = cyc;
        q1.push_back(exp_t'{rd: last1, due: n + 2});
        @(negedge clk);
        check_eq("bf_cmd_wr", 32'(bus1.mem_cmd), 32'd2);
        check_eq("bf_ready1", 32'(bus1.req_ready), 32'd1);
        bus1.req_write = 1'b0; bus1.req_addr = 9'h181; bus1.req_wdata = 16'h0000;
        q1.push_back(exp_t'{rd: 16'hC081, due: n + 4});
        last1 = 16'hC081;
        @(negedge clk);
        check_eq("bf_cmd_rd",  32'(bus1.mem_cmd), 32'd1);
        check_eq("bf_addr_rd", 32'(bus1.mem_addr), 32'h181);
        check_eq("bf_ready2",  32'(bus1.req_ready), 32'd1);
        bus1.req_write = 1'b1; bus1.req_addr = 9'h182; bus1.req_wdata = 16'h2222;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check_eq("bf_full_ready", 32'(bus1.req_ready), 32'd0);
        check_eq("bf_cmd_rd2",    32'(bus1.mem_cmd), 32'd1);
        q1.push_back(exp_t'{rd: last1, due: n + 5});
        @(negedge clk);
        check_eq("bf_cmd_wr2",  32'(bus1.mem_cmd), 32'd2);
        check_eq("bf_addr_wr2", 32'(bus1.mem_addr), 32'h182);
        check_eq("bf_data_wr2", 32'(bus1.write_data), 32'h2222);
        @(negedge clk);
        check_eq("bf_cmd_end",   32'(bus1.mem_cmd), 32'd0);
        check_eq("bf_ready_end", 32'(bus1.req_ready), 32'd1);
`else
        // req_valid held through a load: second request waits for IDLE
        send1(1'b0, 9'h1FF, 16'h0000, 16'hBEEF, n);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 9'h120;
        check_eq("hold_ready1", 32'(bus1.req_ready), 32'd0);
        @(negedge clk);
        check_eq("hold_ready2", 32'(bus1.req_ready), 32'd0);
        check_eq("hold_cmd2",   32'(bus1.mem_cmd), 32'd1);
        @(negedge clk);
        check_eq("hold_gap",    32'(bus1.mem_cmd), 32'd0);
        check_eq("hold_ready3", 32'(bus1.req_ready), 32'd1);
        send1(1'b0, 9'h120, 16'h0000, 16'hC020, n2);
        check_eq("hold_acc_cyc", n2, n + 3);
        check_eq("hold_cmd_b",   32'(bus1.mem_cmd), 32'd1);
        check_eq("hold_addr_b",  32'(bus1.mem_addr), 32'h120);
        repeat (2) @(negedge clk);
`endif

        // RAM write then read back
        send1(1'b1, 9'h130, 16'h7777, 16'h0000, n);
        send1(1'b0, 9'h130, 16'h0000, 16'h7777, n);
        repeat (5) @(negedge clk);
        check_eq("rdata_hold", 32'(bus1.rsp_rdata), 32'h7777);

        // Instance 3 (RD_WAIT=3): load 0x1FF, MREAD for four cycles
        bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 9'h1FF; bus3.req_wdata = 16'h1234;
        guard = 0;
        while (!bus3.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("acc3_ready", 32'(bus3.req_ready), 32'd1);
        n = cyc;
        q3.push_back(exp_t'{rd: 16'hBEEF, due: n + 5});
        @(negedge clk);
        bus3.req_valid = 1'b0;
        check_eq("rd3_addr",  32'(bus3.mem_addr), 32'h1FF);
        check_eq("rd3_wdata", 32'(bus3.write_data), 32'h1234);
        for (int k = 0; k < 4; k++) begin
            check_eq("rd3_cmd", 32'(bus3.mem_cmd), 32'd1);
            @(negedge clk);
        end
        check_eq("rd3_cmd_end", 32'(bus3.mem_cmd), 32'd0);
        @(negedge clk);

        // Instance 3: reset in the middle of RD aborts with no response
        bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 9'h140; bus3.req_wdata = 16'h4321;
        check_eq("ab_ready", 32'(bus3.req_ready), 32'd1);
        @(negedge clk);
        bus3.req_valid = 1'b0;
        check_eq("ab_cmd_rd", 32'(bus3.mem_cmd), 32'd1);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check_eq("ab_cmd",   32'(bus3.mem_cmd), 32'd0);
        check_eq("ab_addr",  32'(bus3.mem_addr), 32'd0);
        check_eq("ab_wdata", 32'(bus3.write_data), 32'd0);
        check_eq("ab_rsp",   32'(bus3.rsp_valid), 32'd0);
        check_eq("ab_rdata", 32'(bus3.rsp_rdata), 32'd0);
        check_eq("ab_ready_in_rst", 32'(bus3.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        #1;
        check_eq("ab_ready_rel", 32'(bus3.req_ready), 32'd1);
        repeat (6) @(negedge clk);
        check_eq("ab_cmd_idle", 32'(bus3.mem_cmd), 32'd0);

        check_eq("q1_empty", q1.size(), 32'd0);
        check_eq("q3_empty", q3.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_master.md
# mem_bus_master

Sequencer that turns single load/store requests from the CPU datapath into cycles on the memory-mapped bus. The bus is the `mem_cmd` / `mem_addr` / `write_data` / `read_data` interface decoded by the board-level memory and I/O block:
- RAM at `mem_addr[8]==1`
- LEDs at 0x100 (write)
- switches at 0x140 (read)

The block owns bus timing, holds commands stable for the RAM's synchronous read latency, captures read data, and returns a one-cycle response pulse to the datapath.

## Interface
Parameters:
- `ADDR_W`, 9, bus address width.
- `DATA_W`, 16, data width.
- `RD_WAIT`, 1, cycles `MREAD` is held before `read_data` is sampled. Legal values are 1..3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  datapath request present.
- `req_ready`  out  1  request accepted on an edge where `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `rsp_rdata`  out  DATA_W  load result; holds until the next load completes.
- `mem_cmd`  out  2  encodings: `MNONE`=2'b00, `MREAD`=2'b01, `MWRITE`=2'b10.
- `mem_addr`  out  ADDR_W  bus address.
- `write_data`  out  DATA_W  bus store data.
- `read_data`  in  DATA_W  bus load data; tristated to z when not selected.

## Operation
States:
- `IDLE`: `mem_cmd`=`MNONE`.
- `WR`: `mem_cmd`=`MWRITE`, lasts 1 cycle.
- `RD`: `mem_cmd`=`MREAD`, lasts `RD_WAIT`+1 cycles, counted by a 2-bit down-counter.

Transitions:
- `IDLE` → `WR` or `RD` on an accepted request, selected by `req_write`.
- `WR` → `IDLE` after its single cycle.
- `RD` → `IDLE` when the counter reaches 0.

Bus outputs:
- All bus outputs are registered.
- `mem_addr` and `write_data` are loaded on acceptance and held through the whole transaction and afterwards in `IDLE`.
- `write_data` is loaded on loads as well, from `req_wdata`; it is don't-care to the bus while `mem_cmd`=`MREAD`.

Completion:
- Load: `read_data` is captured into `rsp_rdata` on the edge ending the last `RD` cycle.
- `rsp_valid` is set for exactly one cycle, the cycle after the last `WR`/`RD` cycle.
- A store also pulses `rsp_valid` and leaves `rsp_rdata` unchanged.

Acceptance and reset:
- `req_ready` = (`state`==`IDLE`) & ~`reset`. Requests while busy are not accepted.
- Reset asserted at any time, including mid-transaction, takes effect immediately:
  - `state`=`IDLE`, `mem_cmd`=`MNONE`, `mem_addr`=0, `write_data`=0, `rsp_valid`=0, `rsp_rdata`=0, buffer empty.
  - The aborted transaction produces no `rsp_valid`.

Address handling:
- Addresses are passed through unmodified; there is no decode, range check or wrap.
- An X or z on `read_data` is captured as-is.

## Timing
Request accepted on the edge ending cycle N:
- Store: `MWRITE` in cycle N+1; `IDLE` and `rsp_valid`=1 in cycle N+2. A new request can be accepted in N+2.
- Load: `MREAD` in cycles N+1 .. N+1+`RD_WAIT`; `rsp_valid`=1 and `rsp_rdata` valid in cycle N+2+`RD_WAIT`.
- Without the buffer, at least one `MNONE` cycle separates consecutive transactions.

## Configuration
Macro: `MEM_REQBUF_EN`.

Defined: one-entry request buffer.
- `req_ready` = buffer empty & ~`reset`.
- A request accepted while `WR`/`RD` is active is stored in the buffer.
- On leaving `WR`/`RD` with the buffer full, the FSM enters the next `WR`/`RD` directly, with no `MNONE` cycle. The buffer empties on that edge.
- A request accepted during the last busy cycle is likewise launched back-to-back.
- The completion pulse for the finished transaction still occurs, overlapping the first cycle of the next transaction.
- A request in `IDLE` with the buffer empty bypasses the buffer, so timing is unchanged.

Undefined: no buffer; `req_ready` high only in `IDLE`.

## Test plan
- Reset in the middle of `RD` → `mem_cmd`=00 in the same cycle; all outputs 0; no `rsp_valid`; `req_ready`=1 the cycle after release.
- Store addr 0x100, data 0x00A5 → `mem_cmd`=10 with `mem_addr`=0x100 and `write_data`=0x00A5 for exactly 1 cycle; `rsp_valid` pulses 1 cycle later; `rsp_rdata` unchanged.
- `RD_WAIT`=1: load addr 0x140 with the bus model driving 0x003C → `MREAD` for 2 cycles; `rsp_valid` at N+3 with `rsp_rdata`=0x003C, held until the next load.
- `RD_WAIT`=3: load addr 0x1FF with RAM returning 0xBEEF → `MREAD` for 4 cycles; `rsp_rdata`=0xBEEF at N+5.
- `req_valid` held high through a load → second request not accepted until `IDLE`; one `MNONE` cycle between the two transactions.
- With `MEM_REQBUF_EN`: store 0x180 then load 0x181, issued on consecutive cycles → `MWRITE` immediately followed by `MREAD` with no gap; two `rsp_valid` pulses; `req_ready` low while the buffer is full.
